// File: rtl/accum_pkg.sv
// Shared encodings, default geometry and lane-range helpers for the
// accumulation buffer.
package accum_pkg;

  localparam int DEF_LANES     = 24;
  localparam int DEF_LANE_W    = 16;
  localparam int DEF_ARR_DEPTH = 16;

  typedef enum logic {
    MODE_OVERWRITE = 1'b0,
    MODE_ACCUM     = 1'b1
  } mode_e;

  function automatic longint lane_max(input int lane_w);
    return (longint'(1) <<< (lane_w - 1)) - longint'(1);
  endfunction

  function automatic longint lane_min(input int lane_w);
    return -(longint'(1) <<< (lane_w - 1));
  endfunction

endpackage

// File: rtl/accum_rmw_buffer_if.sv
// Write-beat and read-request ports of the accumulation buffer.
interface accum_rmw_buffer_if
  import accum_pkg::*;
#(
  parameter int LANES      = DEF_LANES,
  parameter int LANE_W     = DEF_LANE_W,
  parameter int ADDR_WIDTH = $clog2(DEF_ARR_DEPTH)
);

  // Both ports use valid/ready: a transfer happens on a rising edge where
  // valid and ready are both high; valid-side fields are stable while valid.
  logic                    i_in_valid;
  logic                    o_in_ready;
  logic [ADDR_WIDTH-1:0]   i_in_addr;
  logic                    i_in_mode;
  logic [LANES*LANE_W-1:0] i_in_data;
  logic                    i_rd_valid;
  logic                    o_rd_ready;
  logic [ADDR_WIDTH-1:0]   i_rd_addr;
  logic                    i_rd_clear;
  logic                    o_rd_valid;
  logic [LANES*LANE_W-1:0] o_rd_data;
  logic                    o_busy;

  modport master (
    output i_in_valid, i_in_addr, i_in_mode, i_in_data,
    output i_rd_valid, i_rd_addr, i_rd_clear,
    input  o_in_ready, o_rd_ready, o_rd_valid, o_rd_data, o_busy
  );

  modport slave (
    input  i_in_valid, i_in_addr, i_in_mode, i_in_data,
    input  i_rd_valid, i_rd_addr, i_rd_clear,
    output o_in_ready, o_rd_ready, o_rd_valid, o_rd_data, o_busy
  );

endinterface

// File: rtl/accum_lane_add.sv
// One signed lane adder; clamps to the lane range or wraps, per SATURATE.
module accum_lane_add
  import accum_pkg::*;
#(
  parameter int LANE_W   = DEF_LANE_W,
  parameter int SATURATE = 1
) (
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  output logic [LANE_W-1:0] sum
);

  localparam logic signed [LANE_W:0] MAX_V = (LANE_W+1)'(lane_max(LANE_W));
  localparam logic signed [LANE_W:0] MIN_V = (LANE_W+1)'(lane_min(LANE_W));

  logic signed [LANE_W:0] wide;

  assign wide = $signed({a[LANE_W-1], a}) + $signed({b[LANE_W-1], b});

  always_comb begin
    sum = wide[LANE_W-1:0];
    if (SATURATE != 0) begin
      if (wide > MAX_V)      sum = MAX_V[LANE_W-1:0];
      else if (wide < MIN_V) sum = MIN_V[LANE_W-1:0];
    end
  end

endmodule

// File: rtl/accum_rmw_buffer.sv
// Multi-lane accumulation buffer: two-stage read-modify-write pipeline with
// S2->S1 bypass, plus a registered read port with optional clear-on-read.
module accum_rmw_buffer
  import accum_pkg::*;
#(
  parameter int LANES      = DEF_LANES,
  parameter int LANE_W     = DEF_LANE_W,
  parameter int ARR_DEPTH  = DEF_ARR_DEPTH,
  parameter int ADDR_WIDTH = $clog2(ARR_DEPTH),
  parameter int SATURATE   = 1
) (
  input logic               i_clk,
  input logic               i_rst,
  accum_rmw_buffer_if.slave bus
);

  localparam int W = LANES * LANE_W;
  localparam logic [ADDR_WIDTH:0] DEPTH_V = (ADDR_WIDTH+1)'(ARR_DEPTH);

  logic [W-1:0] mem [ARR_DEPTH];

  logic                  s1_valid;
  logic [ADDR_WIDTH-1:0] s1_addr;
  mode_e                 s1_mode;
  logic [W-1:0]          s1_data;
  logic                  s2_valid;
  logic [ADDR_WIDTH-1:0] s2_addr;
  logic [W-1:0]          s2_result;

  logic         in_acc, rd_acc;
  logic         s1_in_range, s2_in_range, rd_in_range;
  logic [W-1:0] old_vec, sum_vec, s1_result;
  logic         rd_valid_q;
  logic [W-1:0] rd_data_q;

  // A pending read blocks new writes so the pipeline drains and the read wins.
  assign bus.o_in_ready = !i_rst && !bus.i_rd_valid;
  assign bus.o_rd_ready = !i_rst && !s1_valid && !s2_valid;
  assign bus.o_busy     = s1_valid || s2_valid;
  assign bus.o_rd_valid = rd_valid_q;
  assign bus.o_rd_data  = rd_data_q;

  assign in_acc = bus.i_in_valid && bus.o_in_ready;
  assign rd_acc = bus.i_rd_valid && bus.o_rd_ready;

  assign s1_in_range = {1'b0, s1_addr} < DEPTH_V;
  assign s2_in_range = {1'b0, s2_addr} < DEPTH_V;
  assign rd_in_range = {1'b0, bus.i_rd_addr} < DEPTH_V;

  // S2 holds a result not yet in mem; forward it to a same-address beat in S1.
  always_comb begin
    old_vec = s1_in_range ? mem[s1_addr] : '0;
    if (s2_valid && (s2_addr == s1_addr)) old_vec = s2_result;
    s1_result = (s1_mode == MODE_ACCUM) ? sum_vec : s1_data;
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    accum_lane_add #(
      .LANE_W   (LANE_W),
      .SATURATE (SATURATE)
    ) u_add (
      .a   (old_vec[k*LANE_W +: LANE_W]),
      .b   (s1_data[k*LANE_W +: LANE_W]),
      .sum (sum_vec[k*LANE_W +: LANE_W])
    );
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid   <= 1'b0;
      s1_addr    <= '0;
      s1_mode    <= MODE_OVERWRITE;
      s1_data    <= '0;
      s2_valid   <= 1'b0;
      s2_addr    <= '0;
      s2_result  <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      for (int i = 0; i < ARR_DEPTH; i++) mem[i] <= '0;
    end else begin
      s1_valid <= in_acc;
      if (in_acc) begin
        s1_addr <= bus.i_in_addr;
        s1_mode <= mode_e'(bus.i_in_mode);
        s1_data <= bus.i_in_data;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_addr   <= s1_addr;
        s2_result <= s1_result;
      end
      // Reads only proceed with both stages empty, so these writes never collide.
      if (s2_valid && s2_in_range) mem[s2_addr] <= s2_result;
      rd_valid_q <= rd_acc;
      if (rd_acc) begin
        rd_data_q <= rd_in_range ? mem[bus.i_rd_addr] : '0;
        if (bus.i_rd_clear && rd_in_range) mem[bus.i_rd_addr] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_accum_rmw_buffer.sv
// Bench for accum_rmw_buffer: saturating and wrapping instances share stimulus
// and are checked every cycle against a transaction-level model.
module tb_accum_rmw_buffer;
  import accum_pkg::*;

  localparam int LANES = 24;
  localparam int LW    = 16;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int W     = LANES * LW;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  // ---------------- clock / reset / DUTs ----------------
  always #5 clk = ~clk;

  accum_rmw_buffer_if #(.LANES(LANES), .LANE_W(LW), .ADDR_WIDTH(AW)) bus_s ();
  accum_rmw_buffer_if #(.LANES(LANES), .LANE_W(LW), .ADDR_WIDTH(AW)) bus_w ();

  assign bus_w.i_in_valid = bus_s.i_in_valid;
  assign bus_w.i_in_addr  = bus_s.i_in_addr;
  assign bus_w.i_in_mode  = bus_s.i_in_mode;
  assign bus_w.i_in_data  = bus_s.i_in_data;
  assign bus_w.i_rd_valid = bus_s.i_rd_valid;
  assign bus_w.i_rd_addr  = bus_s.i_rd_addr;
  assign bus_w.i_rd_clear = bus_s.i_rd_clear;

  accum_rmw_buffer #(.LANES(LANES), .LANE_W(LW), .ARR_DEPTH(DEPTH),
                     .ADDR_WIDTH(AW), .SATURATE(1)) dut_s (
    .i_clk (clk), .i_rst (rst), .bus (bus_s)
  );

  accum_rmw_buffer #(.LANES(LANES), .LANE_W(LW), .ARR_DEPTH(DEPTH),
                     .ADDR_WIDTH(AW), .SATURATE(0)) dut_w (
    .i_clk (clk), .i_rst (rst), .bus (bus_w)
  );

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [W-1:0] model_add(input logic [W-1:0] o, input logic [W-1:0] d,
                                             input bit sat);
    logic [W-1:0] r;
    int a, b, s;
    r = '0;
    for (int k = 0; k < LANES; k++) begin
      a = int'(signed'(o[k*LW +: LW]));
      b = int'(signed'(d[k*LW +: LW]));
      s = a + b;
      if (sat) begin
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
      end
      r[k*LW +: LW] = s[LW-1:0];
    end
    return r;
  endfunction

  function automatic logic [W-1:0] all_lanes(input logic [LW-1:0] v);
    logic [W-1:0] r;
    for (int k = 0; k < LANES; k++) r[k*LW +: LW] = v;
    return r;
  endfunction

  logic [W-1:0] mem_s [DEPTH];
  logic [W-1:0] mem_w [DEPTH];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_wq[$];
  logic [W-1:0] last_s, last_w;
  bit h1, h2, m_rdv, started;

  // Writes take effect in the model at acceptance; reads only proceed once
  // earlier writes have landed, so that ordering is observably equivalent.
  always @(posedge clk) begin
    bit w_acc, r_acc;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_s[i] = '0;
        mem_w[i] = '0;
      end
      exp_q.delete();
      exp_wq.delete();
      last_s  = '0;
      last_w  = '0;
      h1      = 1'b0;
      h2      = 1'b0;
      m_rdv   = 1'b0;
      started = 1'b1;
    end else begin
      w_acc = bus_s.i_in_valid && !bus_s.i_rd_valid;
      r_acc = bus_s.i_rd_valid && !h1 && !h2;
      if (w_acc) begin
        if (bus_s.i_in_mode) begin
          mem_s[bus_s.i_in_addr] = model_add(mem_s[bus_s.i_in_addr], bus_s.i_in_data, 1'b1);
          mem_w[bus_s.i_in_addr] = model_add(mem_w[bus_s.i_in_addr], bus_s.i_in_data, 1'b0);
        end else begin
          mem_s[bus_s.i_in_addr] = bus_s.i_in_data;
          mem_w[bus_s.i_in_addr] = bus_s.i_in_data;
        end
      end
      m_rdv = r_acc;
      if (r_acc) begin
        exp_q.push_back(mem_s[bus_s.i_rd_addr]);
        exp_wq.push_back(mem_w[bus_s.i_rd_addr]);
        if (bus_s.i_rd_clear) begin
          mem_s[bus_s.i_rd_addr] = '0;
          mem_w[bus_s.i_rd_addr] = '0;
        end
      end
      h2 = h1;
      h1 = w_acc;
    end
  end

  // ---------------- per-cycle scoreboard ----------------
  always @(negedge clk) begin
    if (started) begin
      if (m_rdv) begin
        if (exp_q.size() == 0 || exp_wq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL exp_q_underflow got=empty exp=entry");
        end else begin
          last_s = exp_q.pop_front();
          last_w = exp_wq.pop_front();
        end
      end
      check("in_ready_s", W'(bus_s.o_in_ready), W'(!rst && !bus_s.i_rd_valid));
      check("in_ready_w", W'(bus_w.o_in_ready), W'(!rst && !bus_s.i_rd_valid));
      check("rd_ready_s", W'(bus_s.o_rd_ready), W'(!rst && !h1 && !h2));
      check("rd_ready_w", W'(bus_w.o_rd_ready), W'(!rst && !h1 && !h2));
      check("busy_s",     W'(bus_s.o_busy),     W'(h1 || h2));
      check("busy_w",     W'(bus_w.o_busy),     W'(h1 || h2));
      check("rd_valid_s", W'(bus_s.o_rd_valid), W'(m_rdv));
      check("rd_valid_w", W'(bus_w.o_rd_valid), W'(m_rdv));
      check("rd_data_s",  bus_s.o_rd_data, last_s);
      check("rd_data_w",  bus_w.o_rd_data, last_w);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic write_beat(input logic [AW-1:0] a, input logic m, input logic [W-1:0] d);
    bit rdy;
    int n;
    n = 0;
    bus_s.i_in_valid = 1'b1;
    bus_s.i_in_addr  = a;
    bus_s.i_in_mode  = m;
    bus_s.i_in_data  = d;
    forever begin
      @(negedge clk);
      rdy = bus_s.o_in_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
      n++;
      if (n > 40) begin
        checks++;
        errors++;
        $display("FAIL write_timeout got=no_accept exp=accept addr=%0d", a);
        break;
      end
    end
    bus_s.i_in_valid = 1'b0;
  endtask

  task automatic read_entry(input logic [AW-1:0] a, input bit clr,
                            output logic [W-1:0] ds, output logic [W-1:0] dw,
                            output int stalls);
    bit rdy;
    stalls = 0;
    bus_s.i_rd_valid = 1'b1;
    bus_s.i_rd_addr  = a;
    bus_s.i_rd_clear = clr;
    forever begin
      @(negedge clk);
      rdy = bus_s.o_rd_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
      stalls++;
      if (stalls > 40) begin
        checks++;
        errors++;
        $display("FAIL read_timeout got=no_accept exp=accept addr=%0d", a);
        break;
      end
    end
    bus_s.i_rd_valid = 1'b0;
    bus_s.i_rd_clear = 1'b0;
    @(negedge clk);
    ds = bus_s.o_rd_data;
    dw = bus_w.o_rd_data;
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [W-1:0] ds, dw, v;
    int st;
    rst = 1'b1;
    bus_s.i_in_valid = 1'b0;
    bus_s.i_in_addr  = '0;
    bus_s.i_in_mode  = 1'b0;
    bus_s.i_in_data  = '0;
    bus_s.i_rd_valid = 1'b0;
    bus_s.i_rd_addr  = '0;
    bus_s.i_rd_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("busy_after_reset", W'(bus_s.o_busy), '0);
    check("rd_valid_after_reset", W'(bus_s.o_rd_valid), '0);

    for (int a = 0; a < DEPTH; a++) begin
      read_entry(AW'(a), 1'b0, ds, dw, st);
      check("reset_entry_zero", ds, '0);
    end

    // Overwrite then accumulate, mixed signs.
    v = '0; v[15:0] = 16'd100; v[31:16] = 16'hFFF9;
    write_beat(4'd3, 1'b0, v);
    v = '0; v[15:0] = 16'd20;  v[31:16] = 16'hFFFD;
    write_beat(4'd3, 1'b1, v);
    read_entry(4'd3, 1'b0, ds, dw, st);
    v = '0; v[15:0] = 16'd120; v[31:16] = 16'hFFF6;
    check("ovr_acc_sat", ds, v);
    check("ovr_acc_wrap", dw, v);

    // Three back-to-back accumulates to one address rely on the bypass.
    repeat (3) write_beat(4'd5, 1'b1, all_lanes(16'd5));
    read_entry(4'd5, 1'b0, ds, dw, st);
    check("bypass_sum", ds, all_lanes(16'd15));
    check("bypass_sum_w", dw, all_lanes(16'd15));

    // Range limits: saturate vs wrap.
    write_beat(4'd0, 1'b0, all_lanes(16'h7FFF));
    write_beat(4'd0, 1'b1, all_lanes(16'h0001));
    write_beat(4'd1, 1'b0, all_lanes(16'h8000));
    write_beat(4'd1, 1'b1, all_lanes(16'hFFFF));
    read_entry(4'd0, 1'b0, ds, dw, st);
    check("pos_sat", ds, all_lanes(16'h7FFF));
    check("pos_wrap", dw, all_lanes(16'h8000));
    read_entry(4'd1, 1'b0, ds, dw, st);
    check("neg_sat", ds, all_lanes(16'h8000));
    check("neg_wrap", dw, all_lanes(16'h7FFF));

    // Write in flight plus simultaneous write and read-with-clear requests.
    write_beat(4'd2, 1'b0, all_lanes(16'h1234));
    fork
      write_beat(4'd7, 1'b0, all_lanes(16'h0009));
      read_entry(4'd2, 1'b1, ds, dw, st);
    join
    check("held_read_data", ds, all_lanes(16'h1234));
    check("held_read_stalls", W'(st), W'(2));
    read_entry(4'd2, 1'b0, ds, dw, st);
    check("cleared_entry", ds, '0);
    read_entry(4'd7, 1'b0, ds, dw, st);
    check("post_read_write", ds, all_lanes(16'h0009));

    // Reset with two beats in flight.
    write_beat(4'd9, 1'b0, all_lanes(16'h0AAA));
    write_beat(4'd10, 1'b0, all_lanes(16'h0555));
    rst = 1'b1;
    bus_s.i_in_valid = 1'b1;
    #1;
    check("in_ready_in_reset", W'(bus_s.o_in_ready), '0);
    check("rd_ready_in_reset", W'(bus_s.o_rd_ready), '0);
    repeat (2) @(posedge clk);
    #1;
    bus_s.i_in_valid = 1'b0;
    rst = 1'b0;
    check("busy_after_mid_reset", W'(bus_s.o_busy), '0);
    for (int a = 0; a < DEPTH; a++) begin
      read_entry(AW'(a), 1'b0, ds, dw, st);
      check("entry_zero_after_mid_reset", ds, '0);
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/accum_rmw_buffer.md
Name: accum_rmw_buffer

Overview:
Parametrised successor to the plain register-array accumulator: a multi-lane accumulation buffer that performs read-modify-write internally.
- Holds ARR_DEPTH entries of LANES signed lanes.
- Accepts partial-sum vectors over a valid/ready port, and either overwrites an entry or adds the vector into it with per-lane saturation.
- Exposes a registered read port with optional clear-on-read.
- Sits between the PE-array output and the post-processing/writeback stage.

Parameters:
LANES, 24, number of signed lanes per entry
LANE_W, 16, bits per lane (two's complement)
ARR_DEPTH, 16, number of entries
ADDR_WIDTH, $clog2(ARR_DEPTH), entry address width
SATURATE, 1, 1 = clamp lane sums to the signed range, 0 = wrap modulo 2^LANE_W

Ports:
i_clk  in  1  clock; one clock, all state on rising edge
i_rst  in  1  reset, synchronous, active-high
i_in_valid  in  1  write beat valid
o_in_ready  out  1  write beat ready; beat accepted when valid && ready
i_in_addr  in  ADDR_WIDTH  target entry
i_in_mode  in  1  0 = overwrite, 1 = accumulate
i_in_data  in  LANES*LANE_W  lane vector; lane k at bits [k*LANE_W +: LANE_W]
i_rd_valid  in  1  read request
o_rd_ready  out  1  read request accepted when valid && ready
i_rd_addr  in  ADDR_WIDTH  read entry
i_rd_clear  in  1  zero the entry after reading it
o_rd_valid  out  1  read data valid
o_rd_data  out  LANES*LANE_W  read data
o_busy  out  1  either write-pipeline stage occupied

Behaviour:
- Reset (i_rst high at a rising edge):
  - All entries are zeroed and both pipeline stages are invalidated.
  - Outputs after reset: o_rd_valid=0, o_rd_data=0, o_busy=0.
  - While i_rst is high, o_in_ready=0 and o_rd_ready=0.
  - Reset mid-operation drops in-flight beats; they are never written.
- Write pipeline, two stages:
  - Edge E0: accepted beat registers into S1 (addr, mode, data).
  - Cycle after E0 (S1): old = mem[S1.addr], or S2.result if S2 valid and S2.addr == S1.addr (bypass). result = mode ? sat_add(old, data) : data. Result registers into S2.
  - Edge E2: mem[S2.addr] <= S2.result.
  - Entry is updated at the second edge after acceptance.
- Back-to-back accumulates to the same address must give the exact sum; the bypass is mandatory.
- Lane arithmetic:
  - Sign-extend to LANE_W+1 bits, add.
  - If SATURATE=1, clamp to [-2^(LANE_W-1), 2^(LANE_W-1)-1]; otherwise truncate.
  - Lanes are independent; no carry between lanes.
- Handshake priority:
  - o_in_ready = !i_rst && !i_rd_valid (a pending read stalls writes).
  - o_rd_ready = !i_rst && !S1.valid && !S2.valid (reads wait for the pipeline to drain).
  - No deadlock: the pipeline always drains within 2 cycles of writes stalling.
- Read:
  - Request accepted at edge E: o_rd_data = mem[i_rd_addr] and o_rd_valid = 1 from E for one cycle, so latency is 1.
  - If i_rd_clear, the entry is zeroed at the same edge E.
  - o_rd_valid deasserts the cycle after unless another read is accepted. Back-to-back reads allowed, one per cycle.
  - o_rd_data holds its last value when o_rd_valid=0.
- Reads and writes never touch mem at the same edge, so no write/clear collision is possible.
- Address range: out-of-range addresses (ARR_DEPTH not a power of two) are ignored on write and return 0 on read.
- o_busy = S1.valid || S2.valid.

Decomposition:
- Package accum_pkg holds:
  - MODE_OVERWRITE/MODE_ACCUM encodings
  - default LANES/LANE_W/ARR_DEPTH
  - lane min/max constant functions
- Sub-module accum_lane_add: one-lane signed add with SATURATE/wrap. Purely combinational; instantiated LANES times via generate.
- Pipeline, handshake, bypass and memory live in the top module.

Test Plan:
- Reset then read of every address -> o_rd_valid one cycle after each accept, data all 0; o_busy=0.
- Overwrite addr 3 with lane0=100, lane1=-7, then accumulate lane0=+20, lane1=-3 (others 0) -> read addr 3 gives lane0=120, lane1=-10, others 0.
- Three consecutive accumulate beats of +5 in all lanes to addr 5 (no gaps, exercises bypass), starting from 0 -> read gives 15 in every lane.
- SATURATE=1, LANE_W=16: overwrite 32767 then add +1 -> 32767; overwrite -32768 then add -1 -> -32768. With SATURATE=0, same stimulus -> -32768 and 32767.
- Hold i_in_valid and i_rd_valid together, with a write to addr 2 in S1:
  - Expect o_in_ready=0 and o_rd_ready=0 until S1 and S2 drain, then the read is accepted.
  - Data includes the prior write.
  - Read with i_rd_clear=1, then a second read of addr 2 -> 0.
- Assert i_rst while two beats are in flight -> no entry changes, all entries 0, o_busy=0 next cycle, and both readies deasserted while i_rst is high.
